// File: rtl/icache_nway_multiword.sv
// N-way set-associative instruction cache with multi-word lines, burst refill
// and per-set round-robin replacement once every way of a set is valid.
//
// state | meaning
// IDLE  | lookup on cpu_req; a hit answers the same cycle, a miss latches the line and victim
// FETCH | burst request held on the memory port until mem_ready
// FILL  | beats written into the victim line; the last beat validates it
module icache_nway_multiword #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int CACHE_SIZE    = 1024,
    parameter int ASSOCIATIVITY = 4,
    parameter int BLOCK_SIZE    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_valid,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_burst_len,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ready,
    input  logic                  mem_valid,
    input  logic                  mem_last,
    output logic                  cache_hit,
    output logic                  cache_miss,
    output logic                  cache_evict
);

    localparam int SETS      = CACHE_SIZE / (ASSOCIATIVITY * BLOCK_SIZE * 4);
    localparam int WORD_BITS = $clog2(BLOCK_SIZE);
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int WAY_BITS  = $clog2(ASSOCIATIVITY);
    localparam int OFF_BITS  = 2 + WORD_BITS;
    localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS - IDX_BITS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] FILL  = 2'd2;

    logic [1:0]                              state_q;
    logic [SETS-1:0][ASSOCIATIVITY-1:0]      valid_q;
    logic [SETS-1:0][WAY_BITS-1:0]           rr_q;
    logic [TAG_BITS-1:0]                     tag_mem  [SETS][ASSOCIATIVITY];
    logic [DATA_WIDTH-1:0]                   data_mem [SETS][ASSOCIATIVITY][BLOCK_SIZE];

    logic [TAG_BITS-1:0]  miss_tag_q;
    logic [IDX_BITS-1:0]  miss_idx_q;
    logic [WAY_BITS-1:0]  victim_q;
    logic [WORD_BITS-1:0] beat_q;

    logic [WORD_BITS-1:0] req_word;
    logic [IDX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]  req_tag;
    logic                 unused_byte_off;

    assign req_word        = cpu_addr[2 +: WORD_BITS];
    assign req_idx         = cpu_addr[OFF_BITS +: IDX_BITS];
    assign req_tag         = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign unused_byte_off = ^cpu_addr[1:0];

    logic                hit_any;
    logic [WAY_BITS-1:0] hit_way;
    logic                free_any;
    logic [WAY_BITS-1:0] free_way;
    logic [WAY_BITS-1:0] victim;

    // Descending scan so the lowest-numbered matching/free way wins.
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        free_any = 1'b0;
        free_way = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (valid_q[req_idx][WAY_BITS'(w)] && tag_mem[req_idx][WAY_BITS'(w)] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!valid_q[req_idx][WAY_BITS'(w)]) begin
                free_any = 1'b1;
                free_way = WAY_BITS'(w);
            end
        end
    end

    assign victim = free_any ? free_way : rr_q[req_idx];

    logic lookup;
    logic do_hit;
    logic do_miss;

    // Gating with rst keeps the statistics quiet while reset is held.
    assign lookup  = rst && (state_q == IDLE) && cpu_req;
    assign do_hit  = lookup && hit_any;
    assign do_miss = lookup && !hit_any;

    assign cpu_valid     = do_hit;
    assign cpu_data      = do_hit ? data_mem[req_idx][hit_way][req_word] : '0;
    assign cpu_stall     = do_miss || (state_q != IDLE);
    assign cache_hit     = do_hit;
    assign cache_miss    = do_miss;
    assign cache_evict   = do_miss && valid_q[req_idx][victim];
    assign mem_req       = (state_q == FETCH);
    assign mem_addr      = {miss_tag_q, miss_idx_q, {OFF_BITS{1'b0}}};
    assign mem_burst_len = 4'(BLOCK_SIZE - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            rr_q       <= '0;
            beat_q     <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            victim_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (do_miss) begin
                        miss_tag_q <= req_tag;
                        miss_idx_q <= req_idx;
                        victim_q   <= victim;
                        beat_q     <= '0;
                        state_q    <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (mem_valid) begin
                        beat_q <= beat_q + 1'b1;
                        if (mem_last) begin
                            valid_q[miss_idx_q][victim_q] <= 1'b1;
                            rr_q[miss_idx_q] <= (rr_q[miss_idx_q] == WAY_BITS'(ASSOCIATIVITY - 1)) ?
                                                '0 : rr_q[miss_idx_q] + 1'b1;
                            beat_q  <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (state_q == FILL && mem_valid) begin
            data_mem[miss_idx_q][victim_q][beat_q] <= mem_data;
            if (mem_last) begin
                tag_mem[miss_idx_q][victim_q] <= miss_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_icache_nway_multiword.sv
// Randomized bench for icache_nway_multiword against an array-based model of the
// cache contents and replacement rules (default parameters: 8 sets, 4 ways, 8 words).
module tb_icache_nway_multiword;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_data;
    logic        cpu_valid, cpu_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_burst_len;
    logic [31:0] mem_data = '0;
    logic        mem_ready = 1'b0, mem_valid = 1'b0, mem_last = 1'b0;
    logic        cache_hit, cache_miss, cache_evict;

    icache_nway_multiword dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_valid(cpu_valid), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_burst_len(mem_burst_len),
        .mem_data(mem_data), .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_last(mem_last),
        .cache_hit(cache_hit), .cache_miss(cache_miss), .cache_evict(cache_evict)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        m_valid [8][4];
    logic [23:0] m_tag   [8][4];
    logic [31:0] m_data  [8][4][8];
    int          m_rr    [8];
    logic [31:0] fill_words [8];

    function automatic int set_of(input logic [31:0] a);
        return int'((a / 32) % 8);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % 8);
    endfunction

    function automatic logic [23:0] tag_of(input logic [31:0] a);
        return 24'(a / 256);
    endfunction

    function automatic int model_lookup(input logic [31:0] a);
        for (int w = 0; w < 4; w++)
            if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) return w;
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic randomize_fill();
        for (int i = 0; i < 8; i++) fill_words[i] = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0; mem_ready = 1'b0; mem_valid = 1'b0; mem_last = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One CPU fetch; on a model miss it plays the memory side through the whole refill.
    task automatic fetch(input logic [31:0] a, input int ready_delay, input int max_gap);
        int          way, vic, s, gaps;
        logic        exp_evict;
        logic [31:0] line_addr;
        s = set_of(a);
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = a; #1;
        way = model_lookup(a);
        total++;
        if (way >= 0) begin
            if ({cpu_valid, cpu_stall, cache_hit, cache_miss, cache_evict, mem_req} !== 6'b101000 ||
                cpu_data !== m_data[s][way][word_of(a)]) begin
                bad++;
                $display("FAIL hit a=%h flags(v,st,h,m,e,mr)=%b data=%h required flags=101000 data=%h",
                         a, {cpu_valid, cpu_stall, cache_hit, cache_miss, cache_evict, mem_req},
                         cpu_data, m_data[s][way][word_of(a)]);
            end
            @(posedge clk);
        end else begin
            vic = -1;
            for (int w = 0; w < 4; w++) if (!m_valid[s][w] && vic < 0) vic = w;
            if (vic < 0) vic = m_rr[s];
            exp_evict = m_valid[s][vic];
            if ({cpu_valid, cpu_stall, cache_hit, cache_miss, cache_evict} !== {4'b0101, exp_evict} ||
                cpu_data !== 32'h0) begin
                bad++;
                $display("FAIL miss a=%h flags(v,st,h,m,e)=%b data=%h required flags=%b data=0",
                         a, {cpu_valid, cpu_stall, cache_hit, cache_miss, cache_evict}, cpu_data,
                         {4'b0101, exp_evict});
            end
            line_addr = a & ~32'h1F;
            @(posedge clk);
            for (int c = 0; c <= ready_delay; c++) begin
                @(negedge clk);
                cpu_addr = $urandom; mem_ready = (c == ready_delay); #1;
                total++;
                if ({mem_req, cpu_stall, cpu_valid, cache_hit, cache_miss} !== 5'b11000 ||
                    mem_addr !== line_addr || mem_burst_len !== 4'd7) begin
                    bad++;
                    $display("FAIL fetch a=%h cyc=%0d flags(mr,st,v,h,m)=%b addr=%h len=%0d required 11000 addr=%h len=7",
                             a, c, {mem_req, cpu_stall, cpu_valid, cache_hit, cache_miss},
                             mem_addr, mem_burst_len, line_addr);
                end
                @(posedge clk);
            end
            for (int b = 0; b < 8; b++) begin
                gaps = $urandom_range(max_gap, 0);
                for (int g = 0; g <= gaps; g++) begin
                    @(negedge clk);
                    mem_ready = 1'b0; cpu_addr = $urandom;
                    mem_valid = (g == gaps);
                    mem_data  = (g == gaps) ? fill_words[b] : $urandom;
                    mem_last  = (g == gaps) ? (b == 7) : 1'($urandom);
                    #1;
                    total++;
                    if ({mem_req, cpu_stall, cpu_valid, cache_hit, cache_miss, cache_evict} !== 6'b010000 ||
                        cpu_data !== 32'h0) begin
                        bad++;
                        $display("FAIL fill a=%h beat=%0d flags(mr,st,v,h,m,e)=%b data=%h required 010000 data=0",
                                 a, b, {mem_req, cpu_stall, cpu_valid, cache_hit, cache_miss, cache_evict},
                                 cpu_data);
                    end
                    @(posedge clk);
                end
            end
            m_valid[s][vic] = 1'b1;
            m_tag[s][vic]   = tag_of(a);
            for (int i = 0; i < 8; i++) m_data[s][vic][i] = fill_words[i];
            m_rr[s] = (m_rr[s] + 1) % 4;
            @(negedge clk);
            mem_valid = 1'b0; mem_last = 1'b0; cpu_addr = a; #1;
            total++;
            if ({cpu_valid, cpu_stall, cache_hit, cache_miss, cache_evict, mem_req} !== 6'b101000 ||
                cpu_data !== fill_words[word_of(a)]) begin
                bad++;
                $display("FAIL relookup a=%h flags(v,st,h,m,e,mr)=%b data=%h required 101000 data=%h",
                         a, {cpu_valid, cpu_stall, cache_hit, cache_miss, cache_evict, mem_req},
                         cpu_data, fill_words[word_of(a)]);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_idle();
        @(negedge clk);
        cpu_req = 1'b0; cpu_addr = $urandom; #1;
        total++;
        if ({cpu_valid, cpu_stall, cache_hit, cache_miss, cache_evict, mem_req} !== 6'b0 || cpu_data !== 32'h0) begin
            bad++;
            $display("FAIL idle flags(v,st,h,m,e,mr)=%b data=%h required 000000 data=0",
                     {cpu_valid, cpu_stall, cache_hit, cache_miss, cache_evict, mem_req}, cpu_data);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b1; cpu_addr = $urandom; mem_ready = 1'b1; mem_valid = 1'b1; #1;
        model_reset();
        total++;
        if ({mem_req, cache_hit, cache_miss, cache_evict, cpu_valid} !== 5'b0 || cpu_data !== 32'h0) begin
            bad++;
            $display("FAIL reset flags(mr,h,m,e,v)=%b data=%h required 00000 data=0",
                     {mem_req, cache_hit, cache_miss, cache_evict, cpu_valid}, cpu_data);
        end
        @(negedge clk);
        cpu_req = 1'b0; mem_ready = 1'b0; mem_valid = 1'b0;
        rst = 1'b1;
        test_idle();
    endtask

    task automatic test_cold_fill();
        do_reset();
        for (int i = 0; i < 8; i++) fill_words[i] = 32'hA0 + i;
        fetch(32'h0000_0000, 0, 0);
    endtask

    task automatic test_line_hits();
        for (int i = 1; i < 8; i++) fetch(32'(i * 4), 0, 0);
        test_idle();
    endtask

    task automatic test_evict();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            randomize_fill();
            fetch(32'(k * 256), 0, 0);
        end
        randomize_fill();
        fetch(32'h0000_0000, 0, 0);
        fetch(32'h0000_0200, 0, 0);
    endtask

    task automatic test_stall_hold();
        randomize_fill();
        fetch(32'h0000_1240, 5, 0);
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h0000_3360;
        @(negedge clk);
        mem_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            mem_ready = 1'b0; mem_valid = 1'b1; mem_data = $urandom; mem_last = 1'b0;
        end
        @(negedge clk);
        mem_valid = 1'b0;
        rst = 1'b0; #1;
        model_reset();
        total++;
        if ({mem_req, cache_hit, cache_miss, cache_evict, cpu_valid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid_fill flags(mr,h,m,e,v)=%b required 00000",
                     {mem_req, cache_hit, cache_miss, cache_evict, cpu_valid});
        end
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b0;
        test_idle();
        randomize_fill();
        fetch(32'h0000_3360, 1, 1);
    endtask

    task automatic test_gaps();
        randomize_fill();
        fetch(32'h0000_05A0, 2, 3);
        for (int w = 0; w < 8; w++) fetch(32'h0000_05A0 + 32'(w * 4), 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            a = (32'($urandom_range(5, 0)) << 8) | (32'($urandom_range(7, 0)) << 5) |
                (32'($urandom_range(7, 0)) << 2);
            randomize_fill();
            fetch(a, $urandom_range(2, 0), $urandom_range(2, 0));
            if ($urandom_range(3, 0) == 0) test_idle();
        end
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_line_hits();
        test_evict();
        test_stall_hold();
        test_reset_mid_fill();
        test_gaps();
        test_random();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
